motoro_ramp_ctrl: RTL



---
 rtl/motoro_pkg.sv | 26 ++
 rtl/motoro_tick_gen.sv | 25 ++
 rtl/motoro_ramp_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/motoro_pkg.sv
// Shared definitions for the motor ramp controller: state encoding, 50 MHz
// defaults, and the scaled-down timing used in simulation.
package motoro_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RAMP     = 3'd1,
    ST_RUN      = 3'd2,
    ST_STOPPING = 3'd3,
    ST_COAST    = 3'd4
  } state_t;

  localparam int FREQ_W_DEF    = 10;
  localparam int FREQ_MIN_DEF  = 10;
  localparam int STEP_DIV_DEF  = 50000;   // 1 ms at 50 MHz
  localparam int COAST_CYC_DEF = 500000;  // 10 ms at 50 MHz

  localparam int SIM_STEP_DIV  = 4;
  localparam int SIM_COAST_CYC = 20;

  // The sequencer is "busy" whenever it is moving or waiting, i.e. not parked.
  function automatic logic busy_state(state_t s);
    return !(s == ST_IDLE || s == ST_RUN);
  endfunction

endpackage

// File: rtl/motoro_tick_gen.sv
// Free-running divider: one-cycle tick every DIV cycles, restartable by a
// synchronous clear so the first tick lands exactly DIV cycles after it.
module motoro_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (clear || tick)  cnt <= '0;
    else                     cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/motoro_ramp_ctrl.sv
// Soft-start/soft-stop sequencer for the 3-phase motor top. Optional emergency
// stop input is enabled by defining MOTORO_RAMP_ESTOP_EN.
module motoro_ramp_ctrl
  import motoro_pkg::*;
#(
  parameter int FREQ_W    = FREQ_W_DEF,
  parameter int STEP_DIV  = STEP_DIV_DEF,
  parameter int FREQ_MIN  = FREQ_MIN_DEF,
  parameter int COAST_CYC = COAST_CYC_DEF
) (
  input  logic              clk50mhz,
  input  logic              nReset,
  input  logic              cmdRun,
  input  logic              cmdDir,
  input  logic [FREQ_W-1:0] cmdFreq,
  input  logic              cmdLoad,
`ifdef MOTORO_RAMP_ESTOP_EN
  input  logic              eStop,
`endif
  output logic              m3start,
  output logic              m3invOrStop,
  output logic [FREQ_W-1:0] m3freq,
  output logic              busy,
  output logic [2:0]        stateOut
);

  localparam int CW = (COAST_CYC > 1) ? $clog2(COAST_CYC) : 1;
  localparam logic [FREQ_W-1:0] FMIN = FREQ_W'(FREQ_MIN);

  state_t            state, state_n;
  logic              cmd_run, cmd_dir;
  logic [FREQ_W-1:0] cmd_tgt;
  logic [FREQ_W-1:0] freq_n;
  logic              start_n, inv_n;
  logic [CW-1:0]     coast_cnt, coast_n;
  logic              tick;

  // NOTE: the command register is a handful of flops, so it is reset like any
  // other state rather than left to power-up values.
  always_ff @(posedge clk50mhz or negedge nReset) begin
    if (!nReset) begin
      cmd_run <= 1'b0;
      cmd_dir <= 1'b0;
      cmd_tgt <= '0;
    end else begin
`ifdef MOTORO_RAMP_ESTOP_EN
      if (eStop) cmd_run <= 1'b0;
      else
`endif
      if (cmdLoad) begin
        cmd_run <= cmdRun;
        cmd_dir <= cmdDir;
        cmd_tgt <= (cmdFreq < FMIN) ? FMIN : cmdFreq;
      end
    end
  end

  // Restarting the divider on every state change aligns steps to state entry.
  motoro_tick_gen #(.DIV(STEP_DIV)) u_tick (
    .clk   (clk50mhz),
    .rst_n (nReset),
    .clear (state_n != state),
    .tick  (tick)
  );

  always_ff @(posedge clk50mhz or negedge nReset) begin
    if (!nReset) begin
      state       <= ST_IDLE;
      m3start     <= 1'b0;
      m3invOrStop <= 1'b0;
      m3freq      <= '0;
      coast_cnt   <= '0;
    end else begin
      state       <= state_n;
      m3start     <= start_n;
      m3invOrStop <= inv_n;
      m3freq      <= freq_n;
      coast_cnt   <= coast_n;
    end
  end

  // NOTE: every output of this block is defaulted first, so no path infers a latch.
  always_comb begin
    state_n = state;
    freq_n  = m3freq;
    start_n = m3start;
    inv_n   = m3invOrStop;
    coast_n = coast_cnt;

    case (state)
      ST_IDLE: begin
        start_n = 1'b0;
        freq_n  = '0;
        if (cmd_run) begin
          state_n = ST_RAMP;
          start_n = 1'b1;
          inv_n   = cmd_dir;
          freq_n  = FMIN;
        end
      end

      ST_RAMP: begin
        if (!cmd_run || cmd_dir != m3invOrStop) begin
          state_n = ST_STOPPING;
        end else if (m3freq == cmd_tgt) begin
          state_n = ST_RUN;
        end else if (tick) begin
          freq_n = (cmd_tgt > m3freq) ? m3freq + FREQ_W'(1) : m3freq - FREQ_W'(1);
          if (freq_n == cmd_tgt) state_n = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!cmd_run || cmd_dir != m3invOrStop) state_n = ST_STOPPING;
        else if (cmd_tgt != m3freq)             state_n = ST_RAMP;
      end

      ST_STOPPING: begin
        // Stop decision is final: further commands wait until IDLE.
        if (tick) begin
          if (m3freq == FMIN) begin
            state_n = ST_COAST;
            start_n = 1'b0;
            freq_n  = '0;
            coast_n = '0;
          end else begin
            freq_n = m3freq - FREQ_W'(1);
          end
        end
      end

      ST_COAST: begin
        if (coast_cnt == CW'(COAST_CYC - 1)) state_n = ST_IDLE;
        else                                 coast_n = coast_cnt + CW'(1);
      end

      default: state_n = ST_IDLE;
    endcase

`ifdef MOTORO_RAMP_ESTOP_EN
    // Holding the coast counter at zero keeps COAST alive while eStop is high.
    if (eStop) begin
      state_n = ST_COAST;
      start_n = 1'b0;
      freq_n  = '0;
      coast_n = '0;
    end
`endif
  end

  assign busy     = busy_state(state);
  assign stateOut = state;

endmodule
